// File: rtl/uart_rx_if.sv
// Receiver-side bundle: pad line and oversample tick in, received byte and status strobes out.
interface uart_rx_if #(
   parameter int DATA_BITS = 8
);
   logic                 rx_en;
   logic                 rx;
   logic [DATA_BITS-1:0] rx_data;
   logic                 rx_valid;
   logic                 frame_err;
   logic                 busy;

   modport master (
      output rx_en, rx,
      input  rx_data, rx_valid, frame_err, busy
   );

   modport slave (
      input  rx_en, rx,
      output rx_data, rx_valid, frame_err, busy
   );
endinterface

// File: rtl/uart_rx.sv
// 8N1 UART receiver clocked by a 16x oversample tick; start bit re-checked at mid-bit,
// data sampled LSB-first at mid-bit, byte presented with a one-cycle valid strobe.
module uart_rx #(
   parameter int DATA_BITS  = 8,
   parameter int OVERSAMPLE = 16,
   parameter int MID_TICK   = 7
) (
   input  logic     clk_in,
   input  logic     rst_n,
   uart_rx_if.slave bus
);
   localparam int TICK_W = $clog2(OVERSAMPLE);
   localparam int BIT_W  = $clog2(DATA_BITS);
   localparam logic [TICK_W-1:0] LAST_TICK = TICK_W'(OVERSAMPLE - 1);
   localparam logic [TICK_W-1:0] MID       = TICK_W'(MID_TICK);
   localparam logic [BIT_W-1:0]  LAST_BIT  = BIT_W'(DATA_BITS - 1);

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

   logic [1:0]           sync_q;
   state_t               state_q, state_d;
   logic [TICK_W-1:0]    tick_q, tick_d;
   logic [BIT_W-1:0]     bit_q, bit_d;
   logic [DATA_BITS-1:0] shift_q, shift_d;
   logic [DATA_BITS-1:0] data_q, data_d;
   logic                 valid_q, valid_d;
   logic                 ferr_q, ferr_d;
   logic                 rx_s;

   assign rx_s = sync_q[1];

   always_ff @(posedge clk_in or negedge rst_n) begin
      if (!rst_n) begin
         sync_q  <= 2'b11;
         state_q <= IDLE;
         tick_q  <= '0;
         bit_q   <= '0;
         shift_q <= '0;
         data_q  <= '0;
         valid_q <= 1'b0;
         ferr_q  <= 1'b0;
      end else begin
         sync_q  <= {sync_q[0], bus.rx};
         state_q <= state_d;
         tick_q  <= tick_d;
         bit_q   <= bit_d;
         shift_q <= shift_d;
         data_q  <= data_d;
         valid_q <= valid_d;
         ferr_q  <= ferr_d;
      end
   end

   always_comb begin
      state_d = state_q;
      tick_d  = tick_q;
      bit_d   = bit_q;
      shift_d = shift_q;
      data_d  = data_q;
      valid_d = 1'b0;
      ferr_d  = 1'b0;
      if (bus.rx_en) begin
         case (state_q)
            IDLE: begin
               if (!rx_s) begin
                  state_d = START;
                  tick_d  = '0;
               end
            end
            START: begin
               tick_d = tick_q + 1'b1;
               if (tick_q == MID) begin
                  // A line back high at mid-start is a glitch, not a frame.
                  if (!rx_s) begin
                     state_d = DATA;
                     tick_d  = '0;
                     bit_d   = '0;
                  end else begin
                     state_d = IDLE;
                  end
               end
            end
            DATA: begin
               tick_d = tick_q + 1'b1;
               if (tick_q == LAST_TICK) begin
                  shift_d = {rx_s, shift_q[DATA_BITS-1:1]};
                  if (bit_q == LAST_BIT) begin
                     state_d = STOP;
                     tick_d  = '0;
                  end else begin
                     bit_d = bit_q + 1'b1;
                  end
               end
            end
            STOP: begin
               tick_d = tick_q + 1'b1;
               // Leaving at mid stop bit leaves half a bit to catch a back-to-back start edge.
               if (tick_q == LAST_TICK) begin
                  state_d = IDLE;
                  if (rx_s) begin
                     data_d  = shift_q;
                     valid_d = 1'b1;
                  end else begin
                     ferr_d = 1'b1;
                  end
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   assign bus.rx_data   = data_q;
   assign bus.rx_valid  = valid_q;
   assign bus.frame_err = ferr_q;
   assign bus.busy      = (state_q != IDLE);
endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: frames push expected strobes, a monitor pops on each strobe.
module tb_uart_rx;
   logic clk_in = 1'b0;
   logic rst_n  = 1'b0;
   always #5 clk_in = ~clk_in;

   uart_rx_if #(.DATA_BITS(8)) bus ();

   uart_rx #(.DATA_BITS(8), .OVERSAMPLE(16), .MID_TICK(7)) dut (
      .clk_in (clk_in),
      .rst_n  (rst_n),
      .bus    (bus)
   );

   typedef struct {
      logic       ferr;
      logic [7:0] data;
      int         start;
   } exp_t;

   exp_t       q[$];
   int         checks   = 0;
   int         errors   = 0;
   int         cyc      = 0;
   int         tick_div = 4;
   logic [7:0] last_good = 8'h00;

   task automatic check(input string name, input int act, input int req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, req, req);
      end
   endtask

   // Free-running oversample tick, one cycle wide every tick_div clocks.
   initial begin
      int cnt;
      cnt = 0;
      bus.rx_en = 1'b0;
      forever begin
         @(negedge clk_in);
         cnt = (cnt + 1 >= tick_div) ? 0 : cnt + 1;
         bus.rx_en = (cnt == 0);
      end
   end

   always @(posedge clk_in) begin
      exp_t e;
      int   el;
      cyc++;
      #1;
      if (bus.rx_valid && bus.frame_err) check("strobes_exclusive", 1, 0);
      if (bus.rx_valid || bus.frame_err) begin
         if (q.size() == 0) begin
            check("unexpected_strobe", 1, 0);
         end else begin
            e  = q.pop_front();
            el = cyc - e.start;
            check("strobe_kind_ferr", int'(bus.frame_err), int'(e.ferr));
            check("rx_data", int'(bus.rx_data), int'(e.data));
            check("strobe_latency_ok",
                  int'(el >= 152 * tick_div + 2 && el <= 153 * tick_div + 3), 1);
            $display("t=%0t %s rx_data=0x%02h latency=%0d cycles", $time,
                     bus.frame_err ? "frame_err" : "rx_valid ", bus.rx_data, el);
         end
      end
   end

   task automatic hold(input int n_ticks);
      repeat (n_ticks * tick_div) @(negedge clk_in);
   endtask

   task automatic send_frame(input logic [7:0] b, input logic stop);
      exp_t e;
      @(negedge clk_in);
      e.ferr  = !stop;
      e.data  = stop ? b : last_good;
      e.start = cyc;
      if (stop) last_good = b;
      q.push_back(e);
      bus.rx = 1'b0;
      hold(16);
      for (int i = 0; i < 8; i++) begin
         bus.rx = b[i];
         hold(16);
      end
      if (stop) begin
         bus.rx = 1'b1;
         hold(16);
      end else begin
         bus.rx = 1'b0;
         hold(12);
         bus.rx = 1'b1;
         hold(20);
      end
   endtask

   task automatic check_outputs_clear(input string tag);
      check({tag, "_rx_data"},   int'(bus.rx_data),   0);
      check({tag, "_rx_valid"},  int'(bus.rx_valid),  0);
      check({tag, "_frame_err"}, int'(bus.frame_err), 0);
      check({tag, "_busy"},      int'(bus.busy),      0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] b81;
      int         waited;
      bus.rx = 1'b0;

      // Reset held with line toggling
      for (int i = 0; i < 6; i++) begin
         repeat (3) @(negedge clk_in);
         bus.rx = ~bus.rx;
         #1;
         check_outputs_clear("in_reset");
      end
      @(negedge clk_in);
      bus.rx = 1'b1;
      @(negedge clk_in);
      rst_n = 1'b1;
      hold(100);
      check("idle_busy", int'(bus.busy), 0);
      check("idle_rx_data", int'(bus.rx_data), 0);

      // Single good frame
      send_frame(8'hA5, 1'b1);
      hold(5);
      check("a5_busy_after", int'(bus.busy), 0);
      check("a5_rx_data_held", int'(bus.rx_data), 8'hA5);

      // Back-to-back frames, single stop bit, no gap
      send_frame(8'h00, 1'b1);
      send_frame(8'hFF, 1'b1);
      send_frame(8'h55, 1'b1);
      hold(5);
      check("b2b_rx_data_last", int'(bus.rx_data), 8'h55);

      // Start-bit glitch of 4 ticks
      @(negedge clk_in);
      bus.rx = 1'b0;
      hold(4);
      bus.rx = 1'b1;
      hold(30);
      check("glitch_busy", int'(bus.busy), 0);
      check("glitch_rx_data", int'(bus.rx_data), 8'h55);

      // Framing error
      send_frame(8'h3C, 1'b0);
      hold(5);
      check("ferr_busy", int'(bus.busy), 0);
      check("ferr_rx_data", int'(bus.rx_data), 8'h55);

      // Real-rate tick, reset during bit 4 of 0x81
      tick_div = 54;
      hold(20);
      b81 = 8'h81;
      @(negedge clk_in);
      bus.rx = 1'b0;
      hold(16);
      for (int i = 0; i < 4; i++) begin
         bus.rx = b81[i];
         hold(16);
      end
      bus.rx = b81[4];
      hold(8);
      check("midframe_busy_before_rst", int'(bus.busy), 1);
      rst_n = 1'b0;
      #1;
      check_outputs_clear("midframe_rst");
      @(negedge clk_in);
      bus.rx = 1'b1;
      repeat (10) @(negedge clk_in);
      rst_n = 1'b1;
      last_good = 8'h00;
      hold(20);
      check("post_rst_busy", int'(bus.busy), 0);
      send_frame(8'h81, 1'b1);
      hold(5);
      check("final_rx_data", int'(bus.rx_data), 8'h81);

      waited = 0;
      while (q.size() != 0 && waited < 2000) begin
         @(negedge clk_in);
         waited++;
      end
      check("pending_expectations", q.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
